// File: rtl/rr_arb_mux_pkg.sv
// Shared defaults and width helper for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DATA_W = 8;

  // Index width that never collapses to zero for tiny channel counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first request at or after ptr, wrapping.
// With RR_ARB_MUX_PRIO_EN, channel 0 wins outright and the rotation covers 1..NUM_CH-1.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  localparam int unsigned SUM_W = CH_W + 1;

  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [CH_W-1:0]  c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    c     = '0;
`ifdef RR_ARB_MUX_PRIO_EN
    if (req[0]) begin
      grant[0] = 1'b1;
      any      = 1'b1;
    end
`endif
    for (int k = 0; k < int'(NUM_CH); k++) begin
      // Candidate channel (ptr + k) mod NUM_CH without a divider.
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_CH)) sum = sum - SUM_W'(NUM_CH);
      c = sum[CH_W-1:0];
`ifdef RR_ARB_MUX_PRIO_EN
      if (!any && req[c] && (c != '0)) begin
`else
      if (!any && req[c]) begin
`endif
        grant[c] = 1'b1;
        idx      = c;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrating mux with a single registered output stage.
// Optional RR_ARB_MUX_PRIO_EN: channel 0 gets strict priority and does not move the pointer.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int unsigned NUM_CH = DEF_NUM_CH,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   ptr_nxt;
  logic              any;
  logic              load;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign load     = !out_valid || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;
  assign sel_data = in_data[idx*DATA_W +: DATA_W];
  assign ptr_nxt  = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + CH_W'(1);

  // Output register refills whenever it is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= sel_data;
        out_ch   <= idx;
`ifdef RR_ARB_MUX_PRIO_EN
        if (idx != '0) ptr <= ptr_nxt;
`else
        ptr <= ptr_nxt;
`endif
      end
    end
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of input channels (legal 2..16, non-power-of-two allowed).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the per-channel data width in bits (legal 1..64).
REQ-003 SHALL have derived localparam CH_W = max(1, clog2(NUM_CH)), meaning the channel-index width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i.
REQ-007 SHALL have port in_data  input  NUM_CH*DATA_W  packed data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_ready  output  NUM_CH  per-channel accept, combinational.
REQ-009 SHALL have port out_valid  output  1  registered output valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  DATA_W  registered selected data.
REQ-012 SHALL have port out_ch  output  CH_W  registered index of the channel that supplied out_data.

Function
REQ-013 SHALL define an input transfer on channel i as in_valid[i] && in_ready[i] in one cycle, and an output transfer as out_valid && out_ready.
REQ-014 SHALL define load = !out_valid || out_ready, i.e. the output register may accept new data in this cycle.
REQ-015 SHALL compute a one-hot grant among asserted in_valid bits by round-robin search starting at pointer ptr and wrapping from NUM_CH-1 to 0.
REQ-016 SHALL drive in_ready[i] = load && grant[i]; at most one in_ready bit SHALL be high per cycle.
REQ-017 SHALL, on an input transfer from channel g, register out_data = channel g data, out_ch = g, out_valid = 1 at the next rising edge (latency 1 cycle).
REQ-018 SHALL, on an input transfer from channel g, update ptr to (g+1) mod NUM_CH; ptr SHALL NOT change without an input transfer.
REQ-019 SHALL hold out_valid, out_data and out_ch stable while out_valid && !out_ready (no drop, no overwrite).
REQ-020 SHALL, when load is high and no in_valid bit is set, clear out_valid at the next edge and leave out_data/out_ch unchanged.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held high and any request is present (simultaneous output and input transfer in the same cycle).
REQ-022 SHALL keep grant purely combinational from in_valid and ptr; a channel dropping in_valid before acceptance SHALL lose its grant without side effects.

Reset
REQ-023 SHALL, while rst_n is low, force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, independent of clk.
REQ-024 SHALL discard any held output word when reset asserts mid-operation; the first post-reset arbitration starts at channel 0.
REQ-025 SHALL drive in_ready all-zero while rst_n is low.

Configuration
REQ-026 SHALL support macro RR_ARB_MUX_PRIO_EN.
REQ-027 SHALL, with RR_ARB_MUX_PRIO_EN defined, give channel 0 strict priority: if in_valid[0] is set it wins; otherwise round-robin among channels 1..NUM_CH-1, and a channel-0 grant SHALL NOT update ptr.
REQ-028 SHALL, without RR_ARB_MUX_PRIO_EN, treat all channels equally per REQ-015..REQ-018.

Structure
REQ-029 SHALL place default NUM_CH, default DATA_W and a clog2-with-minimum-1 function in package rr_arb_mux_pkg.
REQ-030 SHALL implement grant generation as sub-module rr_arbiter (inputs req, ptr; output one-hot grant and encoded index), instantiated once.

Verification
REQ-031 SHALL verify reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; first grant after release goes to the lowest requesting index at or above 0.
REQ-032 SHALL verify fairness: NUM_CH=4, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle.
REQ-033 SHALL verify backpressure: out_valid=1, out_data=8'hA5, out_ready=0 for 5 cycles with all inputs valid -> out_data stays 8'hA5, in_ready=0, ptr unchanged.
REQ-034 SHALL verify wrap and skip: ptr=3, in_valid=4'b0101 -> channel 0 granted, next grant channel 2.
REQ-035 SHALL verify idle: in_valid=0, out_ready=1 after one word -> out_valid drops next cycle, out_data retains last value.
REQ-036 SHALL verify RR_ARB_MUX_PRIO_EN: in_valid=4'b1111 continuously, out_ready=1 -> out_ch constant 0; release channel 0 -> out_ch resumes round-robin 1,2,3,1.
